// File: rtl/pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// pll_reset_ctrl
//   Reset/lock supervisor for the on-chip PLL, clocked by the free-running
//   board reference clock. It pulses the PLL reset, waits for a stable lock,
//   publishes a debounced pll_ready, retries on lock timeout or lock loss, and
//   parks in a fail state after too many consecutive timeouts.
//
// Ports
//   refclk      in   1        reference clock, the only clock
//   rst_n       in   1        asynchronous active-low reset
//   locked      in   1        PLL lock indication, asynchronous to refclk
//   relock_req  in   1        one-cycle request to restart the PLL
//   pll_rst     out  1        PLL reset, active high (registered)
//   pll_ready   out  1        PLL locked and stable (registered)
//   lock_lost   out  1        one-cycle pulse when lock drops while ready
//   lock_fail   out  1        high while parked in the fail state
//   retry_cnt   out  RETRY_W  timeouts since last success or relock_req
//   loss_cnt    out  LOSS_W   lock-loss events, saturating
// -----------------------------------------------------------------------------
module pll_reset_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 10,
  parameter int HOLDOFF_CYCLES = 5000,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int MAX_RETRIES    = 3,
  parameter int RETRY_W        = 4,
  parameter int LOSS_W         = 8
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               pll_ready,
  output logic               lock_lost,
  output logic               lock_fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  loss_cnt
);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_HOLDOFF,
    S_READY,
    S_FAIL
  } state_t;

  // One shared cycle counter serves both the reset pulse and the holdoff.
  localparam int CNT_MAX = (PLL_RST_CYCLES > HOLDOFF_CYCLES) ? PLL_RST_CYCLES : HOLDOFF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // Sized to hold LOCK_TIMEOUT itself: a holdoff completing on the timeout
  // cycle steps tmo one past the last value before it parks in READY.
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_t                 state, next_state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [CNT_W-1:0]       cnt;
  logic [TMO_W-1:0]       tmo;
  logic [RETRY_W-1:0]     retry_next;
  logic                   in_window;
  logic                   timeout;
  logic                   retry_event;
  logic                   loss_event;
  logic                   enter;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Next-state decision. Priority: relock_req, then holdoff completion, then
  // timeout, then a lock drop. Timeout must beat a lock drop in HOLDOFF:
  // otherwise tmo would step past its terminal value and never fire again.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    next_state  = state;
    retry_event = 1'b0;
    loss_event  = 1'b0;
    retry_next  = retry_cnt + 1'b1;
    in_window   = (state == S_WAIT_LOCK) || (state == S_HOLDOFF);
    timeout     = in_window && (tmo == TMO_LAST);

    if (relock_req) begin
      next_state = S_RESET_PLL;
    end else begin
      case (state)
        S_RESET_PLL: begin
          if (cnt == RST_LAST) next_state = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (timeout) begin
            retry_event = 1'b1;
            next_state  = (retry_next == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
          end else if (locked_s) begin
            next_state = S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if (locked_s && (cnt == HOLD_LAST)) begin
            next_state = S_READY;
          end else if (timeout) begin
            retry_event = 1'b1;
            next_state  = (retry_next == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
          end else if (!locked_s) begin
            next_state = S_WAIT_LOCK;
          end
        end
        S_READY: begin
          if (!locked_s) begin
            loss_event = 1'b1;
            next_state = S_RESET_PLL;
          end
        end
        S_FAIL:  next_state = S_FAIL;
        default: next_state = S_RESET_PLL;
      endcase
    end

    // A relock_req while already in RESET_PLL is a re-entry and restarts the pulse.
    enter = relock_req || (next_state != state);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RESET_PLL;
      sync_q    <= '0;
      cnt       <= '0;
      tmo       <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pll_rst   <= 1'b1;
      pll_ready <= 1'b0;
      lock_lost <= 1'b0;
      lock_fail <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, regardless of statement order.
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
      state  <= next_state;

      if (enter)                                          cnt <= '0;
      else if (state == S_RESET_PLL || state == S_HOLDOFF) cnt <= cnt + 1'b1;

      // tmo spans the whole WAIT_LOCK/HOLDOFF window; lock chatter does not restart it.
      if (state == S_RESET_PLL) tmo <= '0;
      else if (in_window)       tmo <= tmo + 1'b1;

      if (relock_req)                                  retry_cnt <= '0;
      else if (next_state == S_READY && state != S_READY) retry_cnt <= '0;
      else if (retry_event)                            retry_cnt <= retry_next;

      if (loss_event && (loss_cnt != '1)) loss_cnt <= loss_cnt + 1'b1;

      lock_lost <= loss_event;
      pll_rst   <= (next_state == S_RESET_PLL) || (next_state == S_FAIL);
      pll_ready <= (next_state == S_READY);
      lock_fail <= (next_state == S_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_ctrl
//   Directed bench for pll_reset_ctrl with short parameters (SYNC_STAGES=2,
//   PLL_RST_CYCLES=4, HOLDOFF=8, LOCK_TIMEOUT=32, MAX_RETRIES=2). Inputs are
//   driven and outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_pll_reset_ctrl;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       relock_req;
  logic       pll_rst;
  logic       pll_ready;
  logic       lock_lost;
  logic       lock_fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int total = 0;
  int bad   = 0;

  pll_reset_ctrl #(
    .SYNC_STAGES    (2),
    .PLL_RST_CYCLES (4),
    .HOLDOFF_CYCLES (8),
    .LOCK_TIMEOUT   (32),
    .MAX_RETRIES    (2),
    .RETRY_W        (4),
    .LOSS_W         (8)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .locked     (locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .pll_ready  (pll_ready),
    .lock_lost  (lock_lost),
    .lock_fail  (lock_fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  always #10 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int exp_loss;
    int pulses;

    rst_n      = 1'b0;
    locked     = 1'b0;
    relock_req = 1'b0;
    step(3);
    check("rst_pll_rst",   32'(pll_rst),   1);
    check("rst_pll_ready", 32'(pll_ready), 0);
    check("rst_lock_fail", 32'(lock_fail), 0);
    check("rst_lock_lost", 32'(lock_lost), 0);
    check("rst_retry",     32'(retry_cnt), 0);
    check("rst_loss",      32'(loss_cnt),  0);

    // 1: cold start. pll_rst high for 4 cycles, ready 11 edges after locked rises.
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      check("t1_pll_rst", 32'(pll_rst), (i < 4) ? 1 : 0);
    end
    step(6);
    locked = 1'b1;
    step(10);
    check("t1_ready_early", 32'(pll_ready), 0);
    step(1);
    check("t1_ready",   32'(pll_ready), 1);
    check("t1_retry",   32'(retry_cnt), 0);
    check("t1_pll_rst_rdy", 32'(pll_rst), 0);

    // 2: lock loss for 20 cycles.
    step(2);
    locked = 1'b0;
    step(2);
    check("t2_ready_hold", 32'(pll_ready), 1);
    check("t2_lost_early", 32'(lock_lost), 0);
    step(1);
    check("t2_ready_drop", 32'(pll_ready), 0);
    check("t2_lost_pulse", 32'(lock_lost), 1);
    check("t2_loss_cnt",   32'(loss_cnt),  1);
    check("t2_pll_rst_on", 32'(pll_rst),   1);
    step(1);
    check("t2_lost_end",   32'(lock_lost), 0);
    check("t2_pll_rst_2",  32'(pll_rst),   1);
    step(2);
    check("t2_pll_rst_4",  32'(pll_rst),   1);
    step(1);
    check("t2_pll_rst_off", 32'(pll_rst),  0);
    step(13);
    locked = 1'b1;
    step(10);
    check("t2_reready_early", 32'(pll_ready), 0);
    step(1);
    check("t2_reready", 32'(pll_ready), 1);
    check("t2_retry",   32'(retry_cnt), 0);
    check("t2_loss_keep", 32'(loss_cnt), 1);

    // 3: hold locked low -> one retry, then fail, then relock_req.
    locked = 1'b0;
    step(3);
    check("t3_lost",     32'(lock_lost), 1);
    check("t3_loss_cnt", 32'(loss_cnt),  2);
    step(4);
    check("t3_rel1",     32'(pll_rst),   0);
    step(31);
    check("t3_pre_tmo_rst",   32'(pll_rst),   0);
    check("t3_pre_tmo_retry", 32'(retry_cnt), 0);
    step(1);
    check("t3_tmo1_rst",   32'(pll_rst),   1);
    check("t3_tmo1_retry", 32'(retry_cnt), 1);
    check("t3_tmo1_fail",  32'(lock_fail), 0);
    step(3);
    check("t3_repulse",  32'(pll_rst), 1);
    step(1);
    check("t3_rel2",     32'(pll_rst), 0);
    step(31);
    check("t3_pre_fail", 32'(lock_fail), 0);
    step(1);
    check("t3_fail",       32'(lock_fail), 1);
    check("t3_fail_retry", 32'(retry_cnt), 2);
    check("t3_fail_rst",   32'(pll_rst),   1);
    step(20);
    check("t3_fail_stuck", 32'(lock_fail), 1);
    check("t3_rst_stuck",  32'(pll_rst),   1);
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    check("t3_relock_fail",  32'(lock_fail), 0);
    check("t3_relock_retry", 32'(retry_cnt), 0);
    check("t3_relock_rst",   32'(pll_rst),   1);

    // 4: chatter in HOLDOFF, one-cycle drop every 6 cycles; timeout 32 after release.
    step(3);
    check("t4_rst_hold", 32'(pll_rst), 1);
    step(1);
    check("t4_rst_rel",  32'(pll_rst), 0);
    locked = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step(1);
      check("t4_never_ready", 32'(pll_ready), 0);
      check("t4_tmo_edge",    32'(pll_rst), (i == 32) ? 1 : 0);
      locked = (i % 6 != 0);
    end
    check("t4_retry", 32'(retry_cnt), 1);
    check("t4_fail",  32'(lock_fail), 0);

    // 5: 300 lock losses; loss_cnt saturates at 255 and lock_lost keeps pulsing.
    exp_loss = 2;
    pulses   = 0;
    for (int it = 0; it < 300; it++) begin
      n = 0;
      while (pll_ready !== 1'b1 && n < 64) begin
        step(1);
        n++;
      end
      check("t5_ready", 32'(pll_ready), 1);
      locked = 1'b0;
      step(1);
      locked = 1'b1;
      n = 0;
      while (lock_lost !== 1'b1 && n < 8) begin
        step(1);
        n++;
      end
      check("t5_pulse", 32'(lock_lost), 1);
      if (lock_lost === 1'b1) pulses++;
      exp_loss = (exp_loss == 255) ? 255 : exp_loss + 1;
      check("t5_loss_cnt", 32'(loss_cnt), 32'(exp_loss));
    end
    check("t5_pulse_total", 32'(pulses), 300);
    check("t5_saturated",   32'(loss_cnt), 255);

    // 6: async reset mid-HOLDOFF, checked between clock edges.
    step(7);
    check("t6_pre_rst",   32'(pll_rst),   0);
    check("t6_pre_ready", 32'(pll_ready), 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_pll_rst",   32'(pll_rst),   1);
    check("t6_pll_ready", 32'(pll_ready), 0);
    check("t6_lock_lost", 32'(lock_lost), 0);
    check("t6_lock_fail", 32'(lock_fail), 0);
    check("t6_retry",     32'(retry_cnt), 0);
    check("t6_loss",      32'(loss_cnt),  0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("t6_restart_rst", 32'(pll_rst), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
